// File: rtl/toll_lane_arbiter.sv
// Round-robin owner of the shared hipass card reader: grants one lane at a time, runs the
// start/valid handshake with timeout, then times each lane's gate or raises its alarm.
module toll_lane_arbiter #(
    parameter int N_LANES   = 4,
    parameter int TIMEOUT   = 16,
    parameter int GATE_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] car,
    input  logic               rd_valid,
    input  logic [3:0]         rd_id,
    output logic [N_LANES-1:0] grant,
    output logic               rd_start,
    output logic [N_LANES-1:0] gate_open,
    output logic [N_LANES-1:0] alarm,
    output logic               busy,
    output logic [15:0]        tx_count
);

    localparam int PW = $clog2(N_LANES);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GATE_HOLD + 1);

    localparam logic [N_LANES-1:0] LANE0_OH  = N_LANES'(1'b1);
    localparam logic [N_LANES-1:0] NO_LANES  = {N_LANES{1'b0}};
    localparam logic [PW-1:0]      PTR_LAST  = PW'(N_LANES - 1);
    localparam logic [TW-1:0]      TIMER_END = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]      TIMER_ONE = TW'(1'b1);
    localparam logic [GW-1:0]      HOLD_INIT = GW'(GATE_HOLD);
    localparam logic [GW-1:0]      CNT_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0]      CNT_ONE   = GW'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      ptr_r;
    logic [TW-1:0]      timer_r;
    logic [N_LANES-1:0] grant_r;
    logic               rd_start_r;
    logic               busy_r;
    logic [15:0]        tx_count_r;
    logic [N_LANES-1:0] served_r;
    logic [N_LANES-1:0] alarm_r;
    logic [N_LANES-1:0] gate_open_r;
    logic [GW-1:0]      cnt_r      [N_LANES];
    logic [GW-1:0]      cnt_next_s [N_LANES];

    logic [N_LANES-1:0] req_s;
    logic [PW-1:0]      pick_s;
    logic [N_LANES-1:0] lane_oh_s;
    logic               in_wait_s;
    logic               abort_s;
    logic               accept_s;
    logic               fault_s;

    // First requesting lane after ptr, wrapping; lowest offset wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N_LANES-1:0] req,
                                              input logic [PW-1:0]      ptr);
        logic [PW-1:0]      pick;
        logic [N_LANES-1:0] shifted;
        int                 idx;
        pick = ptr;
        for (int k = N_LANES; k >= 1; k--) begin
            idx     = (int'(ptr) + k) % N_LANES;
            shifted = req >> idx;
            if (shifted[0]) begin
                pick = PW'(idx);
            end
        end
        return pick;
    endfunction

    // Request vector, arbitration pick and WAIT-state outcome decode.
    always_comb begin
        req_s     = car & ~served_r & ~alarm_r;
        pick_s    = rr_pick(req_s, ptr_r);
        lane_oh_s = LANE0_OH << ptr_r;
        in_wait_s = (state_r == WAIT);
        abort_s   = in_wait_s && !car[ptr_r];
        accept_s  = in_wait_s && car[ptr_r] && rd_valid && (rd_id != 4'h0);
        fault_s   = in_wait_s && car[ptr_r] && !accept_s &&
                    ((rd_valid && (rd_id == 4'h0)) || (timer_r == TIMER_END));
    end

    // Next value of each lane's gate hold counter.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            if (accept_s && lane_oh_s[i]) begin
                cnt_next_s[i] = HOLD_INIT;
            end else if (cnt_r[i] != CNT_ZERO) begin
                cnt_next_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_next_s[i] = CNT_ZERO;
            end
        end
    end

    // Gate hold counters and registered gate outputs, independent of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            gate_open_r <= NO_LANES;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt_r[i]       <= cnt_next_s[i];
                gate_open_r[i] <= (cnt_next_s[i] != CNT_ZERO);
            end
        end
    end

    // Per-lane served/alarm flags; both drop whenever the lane's car is gone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served_r <= NO_LANES;
            alarm_r  <= NO_LANES;
        end else begin
            served_r <= (served_r | (lane_oh_s & {N_LANES{accept_s | fault_s}})) & car;
            alarm_r  <= (alarm_r | (lane_oh_s & {N_LANES{fault_s}})) & car;
        end
    end

    // Arbitration and reader handshake FSM with registered grant/start/busy/count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            ptr_r      <= PTR_LAST;
            timer_r    <= {TW{1'b0}};
            grant_r    <= NO_LANES;
            rd_start_r <= 1'b0;
            busy_r     <= 1'b0;
            tx_count_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_s) begin
                        state_r    <= START;
                        grant_r    <= LANE0_OH << pick_s;
                        ptr_r      <= pick_s;
                        rd_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        grant_r    <= NO_LANES;
                        rd_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                START: begin
                    state_r    <= WAIT;
                    timer_r    <= {TW{1'b0}};
                    rd_start_r <= 1'b0;
                    busy_r     <= 1'b1;
                end
                WAIT: begin
                    rd_start_r <= 1'b0;
                    if (abort_s || accept_s || fault_s) begin
                        state_r <= IDLE;
                        grant_r <= NO_LANES;
                        busy_r  <= 1'b0;
                        if (accept_s) begin
                            tx_count_r <= tx_count_r + 16'd1;
                        end else begin
                            tx_count_r <= tx_count_r;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    grant_r    <= NO_LANES;
                    rd_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    timer_r    <= {TW{1'b0}};
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign rd_start  = rd_start_r;
    assign gate_open = gate_open_r;
    assign alarm     = alarm_r;
    assign busy      = busy_r;
    assign tx_count  = tx_count_r;

endmodule

// File: tb/tb_toll_lane_arbiter.sv
// Directed bench for toll_lane_arbiter: a vector table for the single-car transaction plus
// hand-written sequences for round-robin, timeout, bad card, abort, races and reset.
module tb_toll_lane_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  car;
    logic        rd_valid;
    logic [3:0]  rd_id;
    logic [3:0]  grant;
    logic        rd_start;
    logic [3:0]  gate_open;
    logic [3:0]  alarm;
    logic        busy;
    logic [15:0] tx_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  car;
        logic        rv;
        logic [3:0]  id;
        logic [3:0]  grant;
        logic        rs;
        logic [3:0]  gate;
        logic [3:0]  alarm;
        logic        busy;
        logic [15:0] tx;
    } vec_t;

    vec_t tbl [13];

    toll_lane_arbiter #(.N_LANES(4), .TIMEOUT(16), .GATE_HOLD(8)) dut (
        .clk(clk), .rst(rst), .car(car), .rd_valid(rd_valid), .rd_id(rd_id),
        .grant(grant), .rd_start(rd_start), .gate_open(gate_open), .alarm(alarm),
        .busy(busy), .tx_count(tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] c, input logic v, input logic [3:0] i,
                                input logic [3:0] g, input logic s, input logic [3:0] gt,
                                input logic [3:0] a, input logic b, input logic [15:0] t);
        vec_t r;
        r.car = c; r.rv = v; r.id = i; r.grant = g; r.rs = s;
        r.gate = gt; r.alarm = a; r.busy = b; r.tx = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic s,
                           input logic [3:0] gt, input logic [3:0] a, input logic b,
                           input logic [15:0] t);
        chk({tag, " grant"}, 16'(grant), 16'(g));
        chk({tag, " rd_start"}, 16'(rd_start), 16'(s));
        chk({tag, " gate_open"}, 16'(gate_open), 16'(gt));
        chk({tag, " alarm"}, 16'(alarm), 16'(a));
        chk({tag, " busy"}, 16'(busy), 16'(b));
        chk({tag, " tx_count"}, tx_count, t);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; car = 4'b0000; rd_valid = 1'b0; rd_id = 4'h0;
        repeat (2) @(negedge clk);
        chk_all(tag, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_start) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: rd_start got 0 for 40 cycles, expected 1", tag);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        int         starts;

        // T1: single car, table driven
        tbl[0]  = mk(4'b0001, 1'b0, 4'h0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'd0);
        tbl[1]  = mk(4'b0001, 1'b0, 4'h0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 16'd0);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(4'b0001, 1'b1, 4'h5, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'd1);
        for (int r = 5; r < 12; r++) begin
            tbl[r] = mk(4'b0001, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'd1);
        end
        tbl[12] = mk(4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd1);

        do_reset("t1 reset");
        for (int r = 0; r < 13; r++) begin
            car = tbl[r].car; rd_valid = tbl[r].rv; rd_id = tbl[r].id;
            @(negedge clk);
            chk_all($sformatf("t1[%0d]", r), tbl[r].grant, tbl[r].rs, tbl[r].gate,
                    tbl[r].alarm, tbl[r].busy, tbl[r].tx);
        end

        // T2: round robin with all lanes present
        do_reset("t2 reset");
        car = 4'b1111;
        for (int l = 0; l < 4; l++) begin
            wait_start($sformatf("t2 start%0d", l));
            exp_g = 4'b0001 << l;
            chk($sformatf("t2 grant%0d", l), 16'(grant), 16'(exp_g));
            @(negedge clk);
            chk($sformatf("t2 pulse%0d", l), 16'(rd_start), 16'd0);
            rd_valid = 1'b1; rd_id = 4'h1;
            @(negedge clk);
            rd_valid = 1'b0; rd_id = 4'h0;
            chk($sformatf("t2 tx%0d", l), tx_count, 16'(l + 1));
            chk($sformatf("t2 gate%0d", l), 16'(gate_open[l]), 16'd1);
        end
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_start) starts++;
        end
        chk("t2 no reserve", 16'(starts), 16'd0);
        chk("t2 idle busy", 16'(busy), 16'd0);
        chk("t2 final tx", tx_count, 16'd4);
        car = 4'b1110;
        @(negedge clk);
        car = 4'b1111;
        wait_start("t2 rearm");
        chk("t2 rearm grant", 16'(grant), 16'(4'b0001));

        // T3: timeout on lane 2
        do_reset("t3 reset");
        car = 4'b0100;
        wait_start("t3 start");
        chk("t3 grant", 16'(grant), 16'(4'b0100));
        repeat (16) @(negedge clk);
        chk("t3 still waiting", 16'(busy), 16'd1);
        chk("t3 no early alarm", 16'(alarm), 16'd0);
        @(negedge clk);
        chk_all("t3 timeout", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        chk("t3 sticky", 16'(alarm), 16'(4'b0100));
        chk("t3 no retry", 16'(busy), 16'd0);
        car = 4'b0000;
        @(negedge clk);
        chk("t3 alarm clear", 16'(alarm), 16'd0);

        // T4: bad card on lane 1, then abort on lane 3
        do_reset("t4 reset");
        car = 4'b0010;
        wait_start("t4 start1");
        chk("t4 grant1", 16'(grant), 16'(4'b0010));
        @(negedge clk);
        rd_valid = 1'b1; rd_id = 4'h0;
        @(negedge clk);
        rd_valid = 1'b0;
        chk_all("t4 badcard", 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 16'd0);
        car = 4'b1010;
        wait_start("t4 start3");
        chk("t4 grant3", 16'(grant), 16'(4'b1000));
        @(negedge clk);
        car = 4'b0010;
        @(negedge clk);
        chk_all("t4 abort", 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 16'd0);

        // T5: accept beats timeout, abort beats accept
        do_reset("t5 reset");
        car = 4'b0001;
        wait_start("t5 start");
        repeat (16) @(negedge clk);
        chk("t5 pre busy", 16'(busy), 16'd1);
        rd_valid = 1'b1; rd_id = 4'h9;
        @(negedge clk);
        rd_valid = 1'b0; rd_id = 4'h0;
        chk_all("t5 race accept", 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 16'd1);
        car = 4'b0000;
        repeat (12) @(negedge clk);
        car = 4'b0001;
        wait_start("t5 start2");
        @(negedge clk);
        car = 4'b0000; rd_valid = 1'b1; rd_id = 4'h9;
        @(negedge clk);
        rd_valid = 1'b0; rd_id = 4'h0;
        chk_all("t5 race abort", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd1);
        @(negedge clk);
        chk("t5 no late gate", 16'(gate_open), 16'd0);

        // T6: asynchronous reset while waiting with lane 0 gate open
        do_reset("t6 reset");
        car = 4'b0011;
        wait_start("t6 start0");
        @(negedge clk);
        rd_valid = 1'b1; rd_id = 4'h5;
        @(negedge clk);
        rd_valid = 1'b0; rd_id = 4'h0;
        wait_start("t6 start1");
        chk("t6 grant1", 16'(grant), 16'(4'b0010));
        @(negedge clk);
        chk("t6 pre gate", 16'(gate_open), 16'(4'b0001));
        chk("t6 pre busy", 16'(busy), 16'd1);
        #2 rst = 1'b0;
        #1 chk_all("t6 async", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0);
        car = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        wait_start("t6 restart");
        chk("t6 lane0 first", 16'(grant), 16'(4'b0001));
        chk("t6 tx after reset", tx_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
